// File: rtl/stopwatch_lap_ctrl.sv
// Run/stop/lap/clear controller for the 100 Hz stopwatch datapath.
// Moore FSM: freezes the display in LAP while the tick counter keeps running.
module stopwatch_lap_ctrl #(
  parameter int unsigned CNT_W  = 14,
  parameter int unsigned LAPN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run_stop,
  input  logic              i_clear,
  input  logic              i_lap,
  input  logic [CNT_W-1:0]  i_count,
  output logic              o_run,
  output logic              o_clear,
  output logic              o_lap_active,
  output logic [CNT_W-1:0]  o_disp,
  output logic [LAPN_W-1:0] o_lap_num,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_LAP   = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   lap_reg_q;
  logic [LAPN_W-1:0]  lap_num_q;
  logic [LAPN_W-1:0]  lap_num_d;

  // Saturating increment; the lap count holds at all-ones rather than wrapping.
  always_comb begin
    lap_num_d = lap_num_q;
    if (lap_num_q != '1) begin
      lap_num_d = lap_num_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STOP;
      lap_reg_q <= '0;
      lap_num_q <= '0;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (i_run_stop) begin
            state_q <= ST_RUN;
          end else if (i_clear) begin
            state_q   <= ST_CLEAR;
            lap_reg_q <= '0;
            lap_num_q <= '0;
          end
        end
        ST_RUN: begin
          if (i_run_stop) begin
            state_q <= ST_STOP;
          end else if (i_lap) begin
            state_q   <= ST_LAP;
            lap_reg_q <= i_count;
            lap_num_q <= lap_num_d;
          end
        end
        ST_LAP: begin
          if (i_run_stop) begin
            state_q <= ST_STOP;
          end else if (i_lap) begin
            lap_reg_q <= i_count;
            lap_num_q <= lap_num_d;
          end else if (i_clear) begin
            state_q <= ST_RUN;
          end
        end
        ST_CLEAR: state_q <= ST_STOP;
        default:  state_q <= ST_STOP;
      endcase
    end
  end

  // Outputs depend on the state register only; o_disp passes i_count through unregistered.
  always_comb begin
    o_run        = (state_q == ST_RUN) || (state_q == ST_LAP);
    o_clear      = (state_q == ST_CLEAR);
    o_lap_active = (state_q == ST_LAP);
    o_disp       = (state_q == ST_LAP) ? lap_reg_q : i_count;
    o_lap_num    = lap_num_q;
    o_state      = state_q;
  end

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Self-checking bench for stopwatch_lap_ctrl: a reference model pushes expected
// output vectors into a scoreboard queue; each scenario task pops and compares.
module tb_stopwatch_lap_ctrl;

  localparam int unsigned CNT_W  = 14;
  localparam int unsigned LAPN_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_run_stop, i_clear, i_lap;
  logic [CNT_W-1:0]  i_count;
  logic              o_run, o_clear, o_lap_active;
  logic [CNT_W-1:0]  o_disp;
  logic [LAPN_W-1:0] o_lap_num;
  logic [1:0]        o_state;

  stopwatch_lap_ctrl #(.CNT_W(CNT_W), .LAPN_W(LAPN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_run_stop   (i_run_stop),
    .i_clear      (i_clear),
    .i_lap        (i_lap),
    .i_count      (i_count),
    .o_run        (o_run),
    .o_clear      (o_clear),
    .o_lap_active (o_lap_active),
    .o_disp       (o_disp),
    .o_lap_num    (o_lap_num),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  // {run, clear, lap_active, disp[13:0], lap_num[3:0], state[1:0]}
  logic [22:0] obs;
  assign obs = {o_run, o_clear, o_lap_active, o_disp, o_lap_num, o_state};

  int checks = 0;
  int errors = 0;
  logic [22:0] sb[$];

  // Reference model state: 0=STOP 1=RUN 2=LAP 3=CLEAR
  int          m_state;
  logic [13:0] m_lap;
  int          m_num;

  function automatic logic [22:0] model_vec(input logic [13:0] cnt);
    logic r, c, l;
    logic [13:0] d;
    r = (m_state == 1) || (m_state == 2);
    c = (m_state == 3);
    l = (m_state == 2);
    d = l ? m_lap : cnt;
    return {r, c, l, d, 4'(m_num), 2'(m_state)};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_lap   = '0;
    m_num   = 0;
  endtask

  // One clock of stimulus: drive at negedge, advance the model, push expectation,
  // then return 1 time unit after the capturing edge with pulses dropped.
  task automatic cycle(input logic rs, input logic cl, input logic lp, input logic [13:0] cnt);
    @(negedge clk);
    i_run_stop = rs;
    i_clear    = cl;
    i_lap      = lp;
    i_count    = cnt;
    if (m_state == 0) begin
      if (rs) m_state = 1;
      else if (cl) begin m_state = 3; m_lap = '0; m_num = 0; end
    end else if (m_state == 1) begin
      if (rs) m_state = 0;
      else if (lp) begin m_state = 2; m_lap = cnt; if (m_num < 15) m_num = m_num + 1; end
    end else if (m_state == 2) begin
      if (rs) m_state = 0;
      else if (lp) begin m_lap = cnt; if (m_num < 15) m_num = m_num + 1; end
      else if (cl) m_state = 1;
    end else begin
      m_state = 0;
    end
    sb.push_back(model_vec(cnt));
    @(posedge clk);
    #1;
    i_run_stop = 1'b0;
    i_clear    = 1'b0;
    i_lap      = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] e;
    reset = 1'b0; i_run_stop = 1'b0; i_clear = 1'b0; i_lap = 1'b0; i_count = 14'd5;
    model_reset();
    #12;
    e = {3'b000, 14'd5, 4'd0, 2'b00};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_state got %h expected %h", obs, e); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_run_stop();
    logic [22:0] e;
    logic [2:0] tbl [3];
    tbl[0] = 3'b100; tbl[1] = 3'b000; tbl[2] = 3'b100;
    for (int i = 0; i < 3; i++) begin
      cycle(tbl[i][2], tbl[i][1], tbl[i][0], 14'(10 + i));
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL run_stop step %0d got %h expected %h", i, obs, e); end
      if (i == 0) begin
        checks++;
        if ({o_run, o_state} !== 3'b101) begin errors++; $display("FAIL run_start got run=%b state=%b expected run=1 state=01", o_run, o_state); end
      end
    end
    checks++;
    if ({o_run, o_state} !== 3'b000) begin errors++; $display("FAIL run_stop_end got run=%b state=%b expected run=0 state=00", o_run, o_state); end
  endtask

  task automatic test_lap();
    logic [22:0] e;
    cycle(1'b1, 1'b0, 1'b0, 14'd100);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL lap_start got %h expected %h", obs, e); end
    cycle(1'b0, 1'b0, 1'b1, 14'd123);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL lap_capture got %h expected %h", obs, e); end
    for (int c = 124; c <= 200; c++) begin
      cycle(1'b0, 1'b0, 1'b0, 14'(c));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL lap_hold cnt %0d got %h expected %h", c, obs, e); end
    end
    checks++;
    if (o_disp !== 14'd123 || o_lap_num !== 4'd1 || o_lap_active !== 1'b1)
      begin errors++; $display("FAIL lap_frozen got disp=%0d num=%0d act=%b expected disp=123 num=1 act=1", o_disp, o_lap_num, o_lap_active); end
    cycle(1'b0, 1'b1, 1'b0, 14'd201);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL lap_release got %h expected %h", obs, e); end
    checks++;
    if (o_state !== 2'b01 || o_disp !== 14'd201 || o_lap_num !== 4'd1)
      begin errors++; $display("FAIL lap_release_vals got state=%b disp=%0d num=%0d expected state=01 disp=201 num=1", o_state, o_disp, o_lap_num); end
  endtask

  task automatic test_clear();
    logic [22:0] e;
    logic [2:0] tbl [6];
    tbl[0] = 3'b100; tbl[1] = 3'b010; tbl[2] = 3'b000;
    tbl[3] = 3'b100; tbl[4] = 3'b001; tbl[5] = 3'b100;
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i][2], tbl[i][1], tbl[i][0], 14'(770 + i));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL clear step %0d got %h expected %h", i, obs, e); end
      if (i == 1) begin
        checks++;
        if (o_clear !== 1'b1 || o_lap_num !== 4'd0) begin errors++; $display("FAIL clear_pulse got clear=%b num=%0d expected clear=1 num=0", o_clear, o_lap_num); end
      end
      if (i == 2) begin
        checks++;
        if (o_clear !== 1'b0 || o_state !== 2'b00) begin errors++; $display("FAIL clear_one_cycle got clear=%b state=%b expected clear=0 state=00", o_clear, o_state); end
      end
      if (i == 4) begin
        checks++;
        if (o_disp !== 14'd774 || o_lap_num !== 4'd1) begin errors++; $display("FAIL clear_relap got disp=%0d num=%0d expected disp=774 num=1", o_disp, o_lap_num); end
      end
    end
  endtask

  task automatic test_priority();
    logic [22:0] e;
    logic [2:0] tbl [7];
    // STOP: rs+cl -> RUN; RUN: rs+lp -> STOP; STOP->RUN->LAP; LAP: lp+cl re-lap; LAP: all -> STOP
    tbl[0] = 3'b110; tbl[1] = 3'b101; tbl[2] = 3'b100; tbl[3] = 3'b001;
    tbl[4] = 3'b011; tbl[5] = 3'b111; tbl[6] = 3'b000;
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i][2], tbl[i][1], tbl[i][0], 14'(300 + 7 * i));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL priority step %0d got %h expected %h", i, obs, e); end
      if (i == 0) begin
        checks++;
        if (o_state !== 2'b01 || o_clear !== 1'b0) begin errors++; $display("FAIL prio_rs_over_clear got state=%b clear=%b expected state=01 clear=0", o_state, o_clear); end
      end
      if (i == 1) begin
        checks++;
        if (o_state !== 2'b00 || o_lap_num !== 4'd1) begin errors++; $display("FAIL prio_rs_over_lap got state=%b num=%0d expected state=00 num=1", o_state, o_lap_num); end
      end
      if (i == 4) begin
        checks++;
        if (o_state !== 2'b10 || o_disp !== 14'd328 || o_lap_num !== 4'd3) begin errors++; $display("FAIL prio_lap_over_clear got state=%b disp=%0d num=%0d expected state=10 disp=328 num=3", o_state, o_disp, o_lap_num); end
      end
    end
  endtask

  task automatic test_saturate();
    logic [22:0] e;
    cycle(1'b1, 1'b0, 1'b0, 14'd999);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL sat_run got %h expected %h", obs, e); end
    cycle(1'b0, 1'b0, 1'b1, 14'd999);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL sat_enter got %h expected %h", obs, e); end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 14'(1000 + 37 * i));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL sat_relap %0d got %h expected %h", i, obs, e); end
      checks++;
      if (o_disp !== 14'(1000 + 37 * i)) begin errors++; $display("FAIL sat_disp %0d got %0d expected %0d", i, o_disp, 1000 + 37 * i); end
    end
    checks++;
    if (o_lap_num !== 4'd15) begin errors++; $display("FAIL sat_count got %0d expected 15", o_lap_num); end
  endtask

  task automatic test_async_reset();
    logic [22:0] e;
    // Currently in LAP; drop reset mid-cycle and check without any clock edge.
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    e = {3'b000, i_count, 4'd0, 2'b00};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL async_reset_lap got %h expected %h", obs, e); end
    model_reset();
    @(negedge clk); reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 14'd50);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL post_reset_lap got %h expected %h", obs, e); end
    cycle(1'b0, 1'b1, 1'b0, 14'd51);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_clear_enter got %h expected %h", obs, e); end
    #2;
    reset = 1'b0;
    #1;
    e = {3'b000, 14'd51, 4'd0, 2'b00};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL async_reset_clear got %h expected %h", obs, e); end
    model_reset();
    @(negedge clk); reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 14'd52);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL post_reset_clear got %h expected %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_run_stop();
    test_lap();
    test_clear();
    test_priority();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1);
  end

endmodule
